cmd_sequencer: RTL and testbench
================================

Name: cmd_sequencer

Overview:
- Upstream command source for the 2-bit arithmetic parser stage; its cmd_out drives the parser's 8-bit cmd_in directly.
- Captures an 8-bit command from board switches on each debounced push-button press and queues it in a small FIFO.
- Presents queued commands one at a time, each held stable for a fixed number of cycles so the parser executes it.
- Command format: [7:6] opcode (00 add, 01 sub, 10 mul, 11 div), [5:4] num1, [3:2] num2, [1:0] reg_id.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive synced cycles a button level must persist before it is accepted (2..65535)
FIFO_DEPTH, 4, command queue entries; power of 2, 2..16
HOLD_CYCLES, 2, cycles each issued command is presented with cmd_valid high (1..255)

Ports:
clk  in  1  single clock; all logic on posedge
rst_n  in  1  synchronous active-low reset
sw_in  in  8  raw switch command word, asynchronous
btn_in  in  1  raw push button, asynchronous, bouncy, active-high
cmd_out  out  8  command presented to the parser
cmd_valid  out  1  high while cmd_out holds a freshly issued command
fifo_full  out  1  queue holds FIFO_DEPTH entries
fifo_empty  out  1  queue holds 0 entries
overflow  out  1  sticky; a press was dropped because the queue was full
div0_reject  out  1  one-cycle pulse, divide-by-zero command filtered (see Optional Feature)

Behaviour:
- Reset: synchronous, active-low, sampled at posedge clk. While rst_n=0, all flops clear: cmd_out=8'h00, cmd_valid=0, fifo_empty=1, fifo_full=0, overflow=0, div0_reject=0, sync flops=0, btn_stable=0, debounce and hold counters=0. Reset mid-HOLD aborts the command and discards all queued entries.
- Synchronizers: btn_in and sw_in each pass through a 2-flop synchronizer.
- Debounce: the counter clears whenever the synced button equals btn_stable. While they differ, the counter increments each cycle. When the count reaches DEBOUNCE_CYCLES-1 and the levels still differ, btn_stable flips and the counter clears. Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- Push: a rising edge of btn_stable produces a one-cycle push pulse that samples the synced sw_in. A button held through reset release yields exactly one push after debounce.
- FIFO: write on push when not full.
  - Push while full with no pop in the same cycle: command dropped; overflow set and held until reset.
  - Push and pop in the same cycle when full: push accepted, count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; an occupancy counter is one bit wider than the pointers.
- Issue FSM, states IDLE and HOLD:
  - IDLE: if the FIFO is non-empty, pop, load cmd_out, set cmd_valid=1, set hold_cnt=HOLD_CYCLES-1, go to HOLD.
  - HOLD with hold_cnt!=0: decrement hold_cnt.
  - HOLD with hold_cnt==0 and FIFO non-empty: pop the next command into cmd_out, reload hold_cnt, stay in HOLD. cmd_valid stays high, so there is no gap between back-to-back commands.
  - HOLD with hold_cnt==0 and FIFO empty: cmd_valid=0, go to IDLE.
- cmd_out holds the last issued command in IDLE; the parser recomputes the same result, which is idempotent.
- Latency: a FIFO write at edge E with IDLE state gives cmd_out/cmd_valid updated at edge E+1. cmd_valid is high for exactly HOLD_CYCLES × (number of consecutive commands) cycles.
- No arithmetic on the command word; it passes through bit-exact.

Optional Feature:
- Macro: CMD_DIV0_FILTER_EN.
- Defined: on push, a word with [7:6]=2'b11 and [3:2]=2'b00 is not enqueued. div0_reject pulses high for the cycle after the push. No overflow or FIFO effect.
- Undefined: such words are enqueued normally and div0_reject is tied to 0.

Test Plan:
- Single press: DEBOUNCE_CYCLES=4, sw_in=8'h19, clean btn high 20 cycles then low -> exactly one push; cmd_out=8'h19, cmd_valid high exactly 2 cycles, then cmd_valid=0 with cmd_out still 8'h19; fifo_empty=1.
- Bounce rejection: DEBOUNCE_CYCLES=16, btn toggling every 3 cycles for 60 cycles then low -> no push, fifo_empty stays 1, cmd_valid stays 0.
- Overflow: HOLD_CYCLES=255, DEBOUNCE_CYCLES=4, six presses 8'h01..8'h06 within 100 cycles -> 8'h01 issued, 8'h02..8'h05 queued, fifo_full=1, 8'h06 dropped, overflow=1; later issue order is 02,03,04,05.
- Back-to-back: queue 8'h4E and 8'h93 while IDLE, HOLD_CYCLES=2 -> cmd_valid high 4 consecutive cycles; cmd_out=8'h4E for 2 cycles, then 8'h93 for 2 cycles.
- Reset mid-hold: rst_n=0 for one cycle during HOLD with 2 entries queued -> next cycle cmd_out=8'h00, cmd_valid=0, fifo_empty=1, overflow=0; no further issue.
- Div-by-zero: sw_in=8'hF0 pressed -> with CMD_DIV0_FILTER_EN, one-cycle div0_reject pulse and fifo_empty stays 1; without it, cmd_out=8'hF0 with cmd_valid for HOLD_CYCLES cycles.

Source files
------------

// File: rtl/cmd_sequencer.sv
// Purpose: debounce a push button, capture the switch word on each press into a small queue, and issue queued commands to the parser.
// Latency: a queue write seen in IDLE is presented on cmd_out/cmd_valid one clock later; each command is held HOLD_CYCLES cycles.
// Backpressure: none downstream; a press arriving while the queue is full (and not popping) is dropped and latches overflow.
// Optional: define CMD_DIV0_FILTER_EN to reject divide-by-zero words (opcode 11, num2 00) at push time.
module cmd_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int HOLD_CYCLES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw_in,
  input  logic       btn_in,
  output logic [7:0] cmd_out,
  output logic       cmd_valid,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       overflow,
  output logic       div0_reject
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  logic             btn_s1, btn_s2;
  logic [7:0]       sw_s1, sw_s2;
  logic             btn_stable, btn_prev;
  logic [15:0]      db_cnt;
  logic             push;
  logic             is_div0;
  logic             wr_en, pop;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [7:0]       mem [FIFO_DEPTH];
  state_t           state;
  logic [7:0]       hold_cnt;

  // Two-flop synchronizers for the asynchronous button and switch inputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      sw_s1  <= 8'h00;
      sw_s2  <= 8'h00;
    end else begin
      btn_s1 <= btn_in;
      btn_s2 <= btn_s1;
      sw_s1  <= sw_in;
      sw_s2  <= sw_s1;
    end
  end

  // Debounce: accept a new button level only after it persists DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt     <= 16'd0;
      btn_stable <= 1'b0;
    end else if (btn_s2 == btn_stable) begin
      db_cnt <= 16'd0;
    end else if (db_cnt == 16'(DEBOUNCE_CYCLES - 1)) begin
      btn_stable <= btn_s2;
      db_cnt     <= 16'd0;
    end else begin
      db_cnt <= db_cnt + 16'd1;
    end
  end

  // Edge detector history; reset to 0 so a button held through reset still yields one push
  always_ff @(posedge clk) begin
    if (!rst_n) btn_prev <= 1'b0;
    else        btn_prev <= btn_stable;
  end

  assign push = btn_stable & ~btn_prev;

`ifdef CMD_DIV0_FILTER_EN
  assign is_div0 = (sw_s2[7:6] == 2'b11) && (sw_s2[3:2] == 2'b00);

  // One-cycle flag for a divide-by-zero word that was kept out of the queue
  always_ff @(posedge clk) begin
    if (!rst_n) div0_reject <= 1'b0;
    else        div0_reject <= push & is_div0;
  end
`else
  assign is_div0     = 1'b0;
  assign div0_reject = 1'b0;
`endif

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  // A full queue still accepts a push when the issuer pops in the same cycle
  assign wr_en = push & ~is_div0 & (~fifo_full | pop);
  assign pop   = ~fifo_empty & ((state == S_IDLE) | (hold_cnt == 8'd0));

  // Queue storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sw_s2;
  end

  // Queue pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && !is_div0 && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  // Issue FSM: pop a command, hold it HOLD_CYCLES cycles, chain directly into the next one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd_out   <= 8'h00;
      cmd_valid <= 1'b0;
      hold_cnt  <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            cmd_out   <= mem[rd_ptr];
            cmd_valid <= 1'b1;
            hold_cnt  <= 8'(HOLD_CYCLES - 1);
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (hold_cnt != 8'd0) begin
            hold_cnt <= hold_cnt - 8'd1;
          end else if (pop) begin
            cmd_out  <= mem[rd_ptr];
            hold_cnt <= 8'(HOLD_CYCLES - 1);
          end else begin
            cmd_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer: table-driven single presses plus hand-written multi-cycle sequences.
// Three instances share the stimulus: A (debounce 4, hold 2), B (debounce 4, hold 255), C (debounce 2, hold 16).
// All outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw_in = 8'h00;
  logic       btn_in = 1'b0;

  logic [7:0] a_cmd, b_cmd, c_cmd;
  logic       a_vld, a_full, a_empty, a_ovf, a_rej;
  logic       b_vld, b_full, b_empty, b_ovf, b_rej;
  logic       c_vld, c_full, c_empty, c_ovf, c_rej;

  always #5 clk = ~clk;

  cmd_sequencer #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4), .HOLD_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .btn_in(btn_in),
    .cmd_out(a_cmd), .cmd_valid(a_vld), .fifo_full(a_full), .fifo_empty(a_empty),
    .overflow(a_ovf), .div0_reject(a_rej));

  cmd_sequencer #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4), .HOLD_CYCLES(255)) dut_b (
    .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .btn_in(btn_in),
    .cmd_out(b_cmd), .cmd_valid(b_vld), .fifo_full(b_full), .fifo_empty(b_empty),
    .overflow(b_ovf), .div0_reject(b_rej));

  cmd_sequencer #(.DEBOUNCE_CYCLES(2), .FIFO_DEPTH(4), .HOLD_CYCLES(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .btn_in(btn_in),
    .cmd_out(c_cmd), .cmd_valid(c_vld), .fifo_full(c_full), .fifo_empty(c_empty),
    .overflow(c_ovf), .div0_reject(c_rej));

  typedef struct {
    logic [7:0] sw;
    logic [7:0] exp_cmd;
    int         exp_vld;
    int         exp_rej;
  } vec_t;

  vec_t vecs [7];
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    btn_in = 1'b0;
    sw_in  = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic press(input logic [7:0] v, input int hi, input int lo);
    sw_in  = v;
    btn_in = 1'b1;
    repeat (hi) @(negedge clk);
    btn_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  int         vc, rc, nec, first_ne, first_v, rises, n4e, n93, vb;
  logic [7:0] cap, last;
  logic       prev_v;
  logic [7:0] seq [$];

  initial begin
    // Single-press vectors on instance A; filtered words leave the previous command in place
    vecs[0] = '{8'h19, 8'h19, 2, 0};
    vecs[1] = '{8'hA5, 8'hA5, 2, 0};
`ifdef CMD_DIV0_FILTER_EN
    vecs[2] = '{8'hF0, 8'hA5, 0, 1};
`else
    vecs[2] = '{8'hF0, 8'hF0, 2, 0};
`endif
    vecs[3] = '{8'h4E, 8'h4E, 2, 0};
`ifdef CMD_DIV0_FILTER_EN
    vecs[4] = '{8'hC3, 8'h4E, 0, 1};
`else
    vecs[4] = '{8'hC3, 8'hC3, 2, 0};
`endif
    vecs[5] = '{8'hFF, 8'hFF, 2, 0};
    vecs[6] = '{8'h00, 8'h00, 2, 0};

    // Reset state
    do_reset();
    chk("rst_cmd_out",    32'(a_cmd),   32'h00);
    chk("rst_cmd_valid",  32'(a_vld),   32'h0);
    chk("rst_fifo_empty", 32'(a_empty), 32'h1);
    chk("rst_fifo_full",  32'(a_full),  32'h0);
    chk("rst_overflow",   32'(a_ovf),   32'h0);
    chk("rst_div0",       32'(a_rej),   32'h0);

    // Table-driven single presses: clean 20-cycle press, then release
    for (int v = 0; v < 7; v++) begin
      vc = 0; rc = 0; nec = 0; first_ne = -1; first_v = -1; cap = 8'hxx;
      sw_in = vecs[v].sw;
      for (int cyc = 0; cyc < 40; cyc++) begin
        btn_in = (cyc < 20);
        @(negedge clk);
        if (a_vld) begin
          if (first_v < 0) begin first_v = cyc; cap = a_cmd; end
          vc++;
        end
        if (!a_empty) begin
          nec++;
          if (first_ne < 0) first_ne = cyc;
        end
        if (a_rej) rc++;
      end
      chk($sformatf("vec%0d_cmd_out", v),     32'(a_cmd),   32'(vecs[v].exp_cmd));
      chk($sformatf("vec%0d_valid_cycles", v), 32'(vc),     32'(vecs[v].exp_vld));
      chk($sformatf("vec%0d_div0_pulses", v),  32'(rc),     32'(vecs[v].exp_rej));
      chk($sformatf("vec%0d_fifo_empty", v),   32'(a_empty), 32'h1);
      chk($sformatf("vec%0d_queued_cycles", v), 32'(nec),   (vecs[v].exp_vld > 0) ? 32'd1 : 32'd0);
      if (vecs[v].exp_vld > 0) begin
        chk($sformatf("vec%0d_issued_word", v), 32'(cap), 32'(vecs[v].exp_cmd));
        chk($sformatf("vec%0d_issue_latency", v), 32'(first_v - first_ne), 32'd1);
      end
    end
    chk("vec_overflow_clear", 32'(a_ovf), 32'h0);

    // Bounce rejection: 3-cycle pulses never survive a 4-cycle debounce
    do_reset();
    sw_in = 8'h77;
    vc = 0; nec = 0;
    for (int i = 0; i < 80; i++) begin
      btn_in = (i < 60) && (((i / 3) % 2) == 0);
      @(negedge clk);
      if (a_vld || b_vld) vc++;
      if (!a_empty || !b_empty) nec++;
    end
    chk("bounce_valid_cycles", 32'(vc),    32'd0);
    chk("bounce_queued_cycles", 32'(nec),  32'd0);
    chk("bounce_cmd_out",      32'(a_cmd), 32'h00);

    // Back-to-back on instance C: second press lands while the first is held
    do_reset();
    vc = 0; rises = 0; n4e = 0; n93 = 0; prev_v = 1'b0; cap = 8'hxx;
    fork
      begin
        press(8'h4E, 6, 6);
        press(8'h93, 6, 6);
      end
      begin
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (c_vld) begin
            vc++;
            if (!prev_v) begin rises++; cap = c_cmd; end
            if (c_cmd == 8'h4E) n4e++;
            if (c_cmd == 8'h93) n93++;
          end
          prev_v = c_vld;
        end
      end
    join
    chk("b2b_valid_cycles", 32'(vc),    32'd32);
    chk("b2b_valid_rises",  32'(rises), 32'd1);
    chk("b2b_first_word",   32'(cap),   32'h4E);
    chk("b2b_4e_cycles",    32'(n4e),   32'd16);
    chk("b2b_93_cycles",    32'(n93),   32'd16);
    chk("b2b_final_cmd",    32'(c_cmd), 32'h93);

    // Overflow on instance B: one issued, four queued, sixth dropped
    do_reset();
    seq.delete();
    vc = 0; rises = 0; prev_v = 1'b0; last = 8'h00;
    fork
      begin
        for (int p = 1; p <= 5; p++) press(8'(p), 8, 8);
        chk("ovf_full_at_depth",   32'(b_full), 32'h1);
        chk("ovf_not_yet_set",     32'(b_ovf),  32'h0);
        chk("ovf_cmd_while_full",  32'(b_cmd),  32'h01);
        press(8'h06, 8, 8);
        chk("ovf_set",             32'(b_ovf),  32'h1);
        chk("ovf_still_full",      32'(b_full), 32'h1);
      end
      begin
        for (int i = 0; i < 1500; i++) begin
          @(negedge clk);
          if (b_vld) begin
            vc++;
            if (!prev_v) rises++;
            if (!prev_v || b_cmd != last) seq.push_back(b_cmd);
            last = b_cmd;
          end
          prev_v = b_vld;
        end
      end
    join
    chk("ovf_issue_count",   32'(seq.size()), 32'd5);
    for (int k = 0; k < 5; k++)
      if (k < seq.size()) chk($sformatf("ovf_order%0d", k), 32'(seq[k]), 32'(k + 1));
    chk("ovf_valid_cycles",  32'(vc),      32'd1275);
    chk("ovf_valid_rises",   32'(rises),   32'd1);
    chk("ovf_sticky",        32'(b_ovf),   32'h1);
    chk("ovf_drained_empty", 32'(b_empty), 32'h1);
    chk("ovf_last_cmd_held", 32'(b_cmd),   32'h05);

    // Reset in the middle of a hold with two entries queued on instance B
    do_reset();
    press(8'h0A, 8, 8);
    press(8'h0B, 8, 8);
    press(8'h0C, 8, 8);
    chk("mid_pre_cmd",   32'(b_cmd),   32'h0A);
    chk("mid_pre_valid", 32'(b_vld),   32'h1);
    chk("mid_pre_empty", 32'(b_empty), 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_cmd",   32'(b_cmd),   32'h00);
    chk("mid_rst_valid", 32'(b_vld),   32'h0);
    chk("mid_rst_empty", 32'(b_empty), 32'h1);
    chk("mid_rst_ovf",   32'(b_ovf),   32'h0);
    rst_n = 1'b1;
    vb = 0; nec = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (b_vld) vb++;
      if (!b_empty) nec++;
    end
    chk("mid_no_reissue", 32'(vb),  32'd0);
    chk("mid_stay_empty", 32'(nec), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
